// File: rtl/keypad_scanner_if.sv
// Key-event handshake between the keypad scanner and its consumer.
// The scanner (master) offers events; the consumer (slave) accepts them.
interface keypad_scanner_if #(
    parameter int KEY_W = 4
);
    logic             evt_valid;
    logic [KEY_W-1:0] evt_key;
    logic             evt_press;
    logic             evt_ready;

    modport master (
        output evt_valid,
        output evt_key,
        output evt_press,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_key,
        input  evt_press,
        output evt_ready
    );
endinterface

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column drive, row sync, per-key debounce
// and a valid/ready event FIFO of accepted presses and releases.
module keypad_scanner #(
    parameter int ROWS           = 3,
    parameter int COLS           = 3,
    parameter int SCAN_DIV       = 16384,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ROWS-1:0]      row,
    input  logic                 scan_en,
    input  logic                 clr_overflow,
    output logic [COLS-1:0]      column,
    output logic [ROWS*COLS-1:0] pressed_map,
    output logic                 overflow,
    keypad_scanner_if.master     evt
);
    localparam int NKEYS = ROWS * COLS;
    localparam int KEY_W = (NKEYS > 1) ? $clog2(NKEYS) : 1;
    localparam int DW    = $clog2(SCAN_DIV);
    localparam int CW    = $clog2(COLS);
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PW    = AW + 1;

    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [3:0]    CNT_LAST   = 4'(DEBOUNCE_SCANS - 1);

    logic [ROWS-1:0]               row_s1_q, row_s2_q;
    logic [DW-1:0]                 dwell_q, dwell_d;
    logic [CW-1:0]                 col_q, col_d;
    logic [COLS-1:0]               column_q, column_d;
    logic [ROWS-1:0]               cap_q, cap_d;
    logic [CW-1:0]                 cap_col_q, cap_col_d;
    logic                          walk_q, walk_d;
    logic [RW-1:0]                 wrow_q, wrow_d;
    logic [NKEYS-1:0]              state_q, state_d;
    logic [NKEYS-1:0][3:0]         cnt_q, cnt_d;
    logic [FIFO_DEPTH-1:0][KEY_W:0] mem_q;
    logic [PW-1:0]                 wptr_q, wptr_d;
    logic [PW-1:0]                 rptr_q, rptr_d;
    logic                          ovf_q, ovf_d;

    logic             capture, walk_go;
    logic [KEY_W-1:0] wkey;
    logic             wsmp, push;
    logic             empty, full, pop, acc;
    logic [KEY_W:0]   head;

    // Column sequencing, end-of-dwell row capture and row walk pacing
    always_comb begin
        dwell_d   = dwell_q;
        col_d     = col_q;
        cap_d     = cap_q;
        cap_col_d = cap_col_q;
        walk_d    = walk_q;
        wrow_d    = wrow_q;
        column_d  = '1;
        capture   = 1'b0;
        walk_go   = scan_en && walk_q;
        if (scan_en) begin
            column_d = ~(COLS'(1) << col_q);
            if (dwell_q == DWELL_LAST) begin
                capture   = 1'b1;
                dwell_d   = '0;
                cap_d     = row_s2_q;
                cap_col_d = col_q;
                col_d     = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
            end else begin
                dwell_d = dwell_q + DW'(1);
            end
        end else begin
            dwell_d = '0;
        end
        if (walk_go) begin
            wrow_d = wrow_q + RW'(1);
            if (wrow_q == ROW_LAST) begin
                walk_d = 1'b0;
                wrow_d = '0;
            end
        end
        if (capture) begin
            walk_d = 1'b1;
            wrow_d = '0;
        end
    end

    // Synchroniser, scan counters and captured column snapshot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_s1_q  <= '1;
            row_s2_q  <= '1;
            dwell_q   <= '0;
            col_q     <= '0;
            column_q  <= '1;
            cap_q     <= '1;
            cap_col_q <= '0;
            walk_q    <= 1'b0;
            wrow_q    <= '0;
        end else begin
            row_s1_q  <= row;
            row_s2_q  <= row_s1_q;
            dwell_q   <= dwell_d;
            col_q     <= col_d;
            column_q  <= column_d;
            cap_q     <= cap_d;
            cap_col_q <= cap_col_d;
            walk_q    <= walk_d;
            wrow_q    <= wrow_d;
        end
    end

    // One key per walk cycle: count disagreeing samples, flip on limit
    always_comb begin
        wkey    = KEY_W'(int'(wrow_q) * COLS + int'(cap_col_q));
        wsmp    = ~cap_q[wrow_q];
        state_d = state_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        if (walk_go) begin
            if (wsmp == state_q[wkey]) begin
                cnt_d[wkey] = '0;
            end else if (cnt_q[wkey] == CNT_LAST) begin
                state_d[wkey] = wsmp;
                cnt_d[wkey]   = '0;
                push          = 1'b1;
            end else begin
                cnt_d[wkey] = cnt_q[wkey] + 4'd1;
            end
        end
    end

    // Debounced key state and per-key counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FIFO control: a pop frees room for a same-cycle push when full
    always_comb begin
        empty  = (wptr_q == rptr_q);
        full   = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        pop    = !empty && evt.evt_ready;
        acc    = push && (!full || pop);
        wptr_d = wptr_q + PW'(acc);
        rptr_d = rptr_q + PW'(pop);
        ovf_d  = ovf_q;
        if (clr_overflow) ovf_d = 1'b0;
        if (push && full && !pop) ovf_d = 1'b1;
    end

    // FIFO storage, pointers and sticky overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (acc) mem_q[wptr_q[AW-1:0]] <= {wsmp, wkey};
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
        end
    end

    assign head          = mem_q[rptr_q[AW-1:0]];
    assign evt.evt_valid = !empty;
    assign evt.evt_key   = empty ? '0 : head[KEY_W-1:0];
    assign evt.evt_press = !empty && head[KEY_W];
    assign column        = column_q;
    assign pressed_map   = state_q;
    assign overflow      = ovf_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad pin model, event-level reference
// model compared every cycle, plus directed literal checks.
module tb_keypad_scanner;
    localparam int ROWS  = 3;
    localparam int COLS  = 3;
    localparam int SD    = 16;
    localparam int DEB   = 4;
    localparam int DEPTH = 2;
    localparam int NK    = ROWS * COLS;
    localparam int KW    = 4;
    localparam int SCAN  = SD * COLS;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, scan_en, clr_ovf;
    logic [NK-1:0]   key_down;
    logic [ROWS-1:0] row_w;
    logic [COLS-1:0] column;
    logic [NK-1:0]   pmap;
    logic            ovf;

    keypad_scanner_if #(.KEY_W(KW)) evt ();

    keypad_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD),
        .DEBOUNCE_SCANS(DEB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(rst_n), .row(row_w), .scan_en(scan_en),
        .clr_overflow(clr_ovf), .column(column), .pressed_map(pmap),
        .overflow(ovf), .evt(evt)
    );

    // Default-parameter instance, used for reset and column cadence
    logic       rst0_n;
    logic [2:0] col0;
    logic [8:0] pmap0;
    logic       ovf0;
    keypad_scanner_if #(.KEY_W(4)) evt0 ();
    assign evt0.evt_ready = 1'b1;

    keypad_scanner dut0 (
        .clk(clk), .reset(rst0_n), .row(3'b111), .scan_en(1'b1),
        .clr_overflow(1'b0), .column(col0), .pressed_map(pmap0),
        .overflow(ovf0), .evt(evt0)
    );

    // Keypad pins: a held key pulls its row low while its column is driven
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign row_w[r] = ~|(key_down[r*COLS +: COLS] & ~column);
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Events accepted by the consumer, as {press, key}
    logic [4:0] log_q[$];
    always @(posedge clk)
        if (rst_n && evt.evt_valid && evt.evt_ready)
            log_q.push_back({evt.evt_press, evt.evt_key});

    function automatic logic [4:0] logged(input int i);
        return (log_q.size() > i) ? log_q[i] : 5'h1f;
    endfunction

    // Reference model: scan timing, sample history, debounce and queue
    bit [ROWS-1:0] m_s1 = '1, m_s2 = '1;
    int            m_dwell = 0, m_col = 0;
    bit [COLS-1:0] m_colout = '1;
    int            w_key[$];
    bit            w_smp[$];
    bit [NK-1:0]   m_state = '0;
    int            m_cnt[NK];
    bit [4:0]      m_fifo[$];
    bit            m_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin : mdl
        int k;
        bit s, mpush, mpop, mset;
        bit [4:0] ent;
        if (!rst_n) begin
            m_s1 = '1; m_s2 = '1;
            m_dwell = 0; m_col = 0; m_colout = '1;
            w_key.delete(); w_smp.delete();
            m_state = '0; m_fifo.delete(); m_ovf = 1'b0;
            foreach (m_cnt[i]) m_cnt[i] = 0;
        end else begin
            mpush = 1'b0; mset = 1'b0; ent = '0;
            mpop = (m_fifo.size() > 0) && evt.evt_ready;
            if (scan_en && w_key.size() > 0) begin
                k = w_key.pop_front();
                s = w_smp.pop_front();
                if (s == m_state[k]) m_cnt[k] = 0;
                else begin
                    m_cnt[k]++;
                    if (m_cnt[k] == DEB) begin
                        m_state[k] = s;
                        m_cnt[k] = 0;
                        mpush = 1'b1;
                        ent = {s, 4'(k)};
                    end
                end
            end
            m_colout = scan_en ? ~(COLS'(1) << m_col) : '1;
            if (scan_en) begin
                if (m_dwell == SD - 1) begin
                    for (int r = 0; r < ROWS; r++) begin
                        w_key.push_back(r * COLS + m_col);
                        w_smp.push_back(!m_s2[r]);
                    end
                    m_dwell = 0;
                    m_col = (m_col + 1) % COLS;
                end else m_dwell++;
            end else m_dwell = 0;
            m_s2 = m_s1;
            m_s1 = row_w;
            if (mpop) void'(m_fifo.pop_front());
            if (mpush) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back(ent);
                else mset = 1'b1;
            end
            if (mset) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
        end
    end

    // Every cycle: all outputs of the main instance against the model
    always @(negedge clk) begin : cmp
        logic [18:0] act, exp;
        logic [3:0]  hk;
        logic        hp;
        hk = (m_fifo.size() > 0) ? m_fifo[0][3:0] : 4'd0;
        hp = (m_fifo.size() > 0) ? m_fifo[0][4] : 1'b0;
        exp = {m_colout, 1'(m_fifo.size() > 0), hk, hp, m_state, m_ovf};
        act = {column, evt.evt_valid, evt.evt_key, evt.evt_press,
               pmap, ovf};
        chk("model {col,vld,key,prs,map,ovf}", 64'(act), 64'(exp));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_col(input logic [COLS-1:0] target);
        int n = 0;
        while (column === target && n < 4 * SCAN) begin
            @(negedge clk); n++;
        end
        while (column !== target && n < 8 * SCAN) begin
            @(negedge clk); n++;
        end
        chk("col_align", 64'(column), 64'(target));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; scan_en = 1'b1; clr_ovf = 1'b0;
        key_down = '0; evt.evt_ready = 1'b1; rst0_n = 1'b0;
        fork
            begin : main_seq
                cyc(3);
                chk("rst column", 64'(column), 64'(3'b111));
                chk("rst valid", 64'(evt.evt_valid), 64'(0));
                chk("rst map", 64'(pmap), 64'(0));
                chk("rst ovf", 64'(ovf), 64'(0));
                rst_n = 1'b1;
                cyc(1);
                chk("first column", 64'(column), 64'(3'b110));

                // single key 5 (row 1, col 2)
                key_down[5] = 1'b1;
                cyc(5 * SCAN);
                chk("k5 map", 64'(pmap), 64'(9'b000100000));
                chk("k5 count", 64'(log_q.size()), 64'(1));
                chk("k5 press", 64'(logged(0)), 64'({1'b1, 4'd5}));
                log_q.delete();
                key_down[5] = 1'b0;
                cyc(5 * SCAN);
                chk("k5 rel map", 64'(pmap), 64'(0));
                chk("k5 rel", 64'(logged(0)), 64'({1'b0, 4'd5}));
                chk("k5 rel count", 64'(log_q.size()), 64'(1));
                log_q.delete();

                // bounce on key 0, then 3 and 4 consecutive captures
                wait_col(3'b110);
                for (int i = 0; i < 6; i++) begin
                    key_down[0] = (i % 2 == 0);
                    cyc(SCAN);
                end
                key_down[0] = 1'b1;
                cyc(3 * SCAN);
                key_down[0] = 1'b0;
                cyc(2 * SCAN);
                chk("bounce map", 64'(pmap), 64'(0));
                chk("bounce count", 64'(log_q.size()), 64'(0));
                key_down[0] = 1'b1;
                cyc(4 * SCAN);
                key_down[0] = 1'b0;
                cyc(SCAN);
                chk("k0 map", 64'(pmap), 64'(9'b000000001));
                chk("k0 press", 64'(logged(0)), 64'({1'b1, 4'd0}));
                cyc(4 * SCAN);
                chk("k0 rel", 64'(logged(1)), 64'({1'b0, 4'd0}));
                chk("k0 count", 64'(log_q.size()), 64'(2));
                log_q.delete();

                // keys 1 and 7 together (col 1)
                wait_col(3'b101);
                key_down[1] = 1'b1; key_down[7] = 1'b1;
                cyc(5 * SCAN);
                chk("multi map", 64'(pmap), 64'(9'b010000010));
                chk("multi first", 64'(logged(0)), 64'({1'b1, 4'd1}));
                chk("multi second", 64'(logged(1)), 64'({1'b1, 4'd7}));
                key_down[1] = 1'b0; key_down[7] = 1'b0;
                cyc(5 * SCAN);
                chk("multi count", 64'(log_q.size()), 64'(4));
                log_q.delete();

                // FIFO full: three presses, consumer stalled
                evt.evt_ready = 1'b0;
                key_down[2] = 1'b1; key_down[5] = 1'b1; key_down[8] = 1'b1;
                cyc(5 * SCAN);
                chk("full valid", 64'(evt.evt_valid), 64'(1));
                chk("full head", 64'(evt.evt_key), 64'(2));
                chk("full ovf", 64'(ovf), 64'(1));
                chk("full map", 64'(pmap), 64'(9'b100100100));
                clr_ovf = 1'b1;
                cyc(1);
                clr_ovf = 1'b0;
                chk("clr ovf", 64'(ovf), 64'(0));
                evt.evt_ready = 1'b1;
                cyc(1);
                chk("pop head", 64'(evt.evt_key), 64'(5));
                cyc(1);
                chk("drained", 64'(evt.evt_valid), 64'(0));
                chk("drain 0", 64'(logged(0)), 64'({1'b1, 4'd2}));
                chk("drain 1", 64'(logged(1)), 64'({1'b1, 4'd5}));
                key_down = '0;
                cyc(5 * SCAN);
                chk("full rel count", 64'(log_q.size()), 64'(5));
                log_q.delete();

                // scan_en pause during column 1 with a pending count
                wait_col(3'b101);
                key_down[4] = 1'b1;
                cyc(2 * SCAN + 5);
                scan_en = 1'b0;
                cyc(1);
                chk("pause column", 64'(column), 64'(3'b111));
                cyc(99);
                chk("pause column end", 64'(column), 64'(3'b111));
                chk("pause map", 64'(pmap), 64'(0));
                scan_en = 1'b1;
                cyc(1);
                chk("resume col1", 64'(column), 64'(3'b101));
                cyc(15);
                chk("resume col1 end", 64'(column), 64'(3'b101));
                cyc(1);
                chk("resume col2", 64'(column), 64'(3'b011));
                chk("k4 not yet", 64'(pmap), 64'(0));
                cyc(SCAN + 10);
                chk("k4 map", 64'(pmap), 64'(9'b000010000));
                chk("k4 press", 64'(logged(0)), 64'({1'b1, 4'd4}));
                key_down[4] = 1'b0;
                cyc(5 * SCAN);
                chk("k4 rel count", 64'(log_q.size()), 64'(2));
                log_q.delete();

                // reset mid-scan with queued events and overflow
                evt.evt_ready = 1'b0;
                key_down[3] = 1'b1; key_down[4] = 1'b1; key_down[5] = 1'b1;
                cyc(5 * SCAN + 3);
                chk("pre-rst ovf", 64'(ovf), 64'(1));
                #2 rst_n = 1'b0;
                #1;
                chk("mid rst column", 64'(column), 64'(3'b111));
                chk("mid rst valid", 64'(evt.evt_valid), 64'(0));
                chk("mid rst map", 64'(pmap), 64'(0));
                chk("mid rst ovf", 64'(ovf), 64'(0));
                cyc(3);
                key_down = '0;
                evt.evt_ready = 1'b1;
                rst_n = 1'b1;
                cyc(1);
                chk("post rst column", 64'(column), 64'(3'b110));
                cyc(5 * SCAN);
                chk("post rst count", 64'(log_q.size()), 64'(0));
                chk("post rst map", 64'(pmap), 64'(0));
            end
            begin : default_seq
                cyc(2);
                chk("d0 rst column", 64'(col0), 64'(3'b111));
                chk("d0 rst valid", 64'(evt0.evt_valid), 64'(0));
                rst0_n = 1'b1;
                cyc(100);
                #2 rst0_n = 1'b0;
                #1;
                chk("d0 mid rst column", 64'(col0), 64'(3'b111));
                chk("d0 mid rst map", 64'(pmap0), 64'(0));
                chk("d0 mid rst ovf", 64'(ovf0), 64'(0));
                cyc(1);
                rst0_n = 1'b1;
                cyc(1);
                chk("d0 col0", 64'(col0), 64'(3'b110));
                cyc(16383);
                chk("d0 col0 end", 64'(col0), 64'(3'b110));
                cyc(1);
                chk("d0 col1", 64'(col0), 64'(3'b101));
                cyc(16384);
                chk("d0 col2", 64'(col0), 64'(3'b011));
                cyc(16384);
                chk("d0 wrap", 64'(col0), 64'(3'b110));
            end
        join
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
